fetch_mem_stage: RTL and testbench
==================================

// Module: fetch_mem_stage
// PURPOSE
// - IF stage for the 5-stage pipeline: owns the PC and drives a multi-cycle instruction
//   memory (one outstanding request, req/done handshake). Presents the IF/ID register
//   (instr, PC+2, valid) to decode.
// - Consumes the hazard-unit stall and the execute-stage redirect (taken branch/jump).
//   Stops fetching after a HALT opcode.
// PARAMETERS
// - RESET_PC   16'h0000  PC loaded on reset
// - NOP_INSTR  16'h0800  bubble instruction placed in IF/ID (opcode 5'b00001)
// - HALT_OP    5'b00000  opcode in instr[15:11] that stops fetch
// PORTS
// - clk         in   1   clock, all state updates on rising edge
// - rst         in   1   synchronous, active-low reset (rst==0 at an edge resets)
// - stall       in   1   hazard unit: hold IF/ID and the PC
// - redirect    in   1   execute: take redirect_pc this cycle
// - redirect_pc in   16  redirect target
// - imem_req    out  1   one-cycle request pulse
// - imem_addr   out  16  fetch address, valid while imem_req==1
// - imem_done   in   1   response strobe, >=1 cycle after imem_req
// - imem_data   in   16  instruction, valid with imem_done
// - imem_err    in   1   response error, valid with imem_done
// - instr_out   out  16  IF/ID instruction
// - next_pc_out out  16  IF/ID PC+2 of instr_out
// - valid_out   out  1   IF/ID holds a real instruction
// - halted      out  1   HALT fetched, fetch stopped
// - err         out  1   sticky error
// BEHAVIOUR
// - Reset: pc=RESET_PC, state=REQ, instr_out=NOP_INSTR, next_pc_out=0, valid_out=0,
//   imem_req=0, halted=0, err=0, hold buffer cleared.
// - States: REQ, WAIT, HOLD, DRAIN, HALTED.
// - REQ: imem_req=1, imem_addr=pc; -> WAIT.
// - WAIT: on imem_done with stall=0: IF/ID<={data, pc+2, 1}, pc<=pc+2, -> REQ.
//   On imem_done with stall=1: latch data into hold buffer, -> HOLD.
//   Opcode HALT_OP is delivered and the state goes to HALTED, not REQ; halted=1.
// - HOLD: IF/ID unchanged while stall=1. When stall=0, IF/ID<=buffer, pc<=pc+2,
//   -> REQ, or -> HALTED when the buffer holds HALT.
// - IF/ID update rules: stall=1 holds IF/ID. stall=0 with nothing delivered loads
//   the bubble {NOP_INSTR, unchanged, valid=0}.
// - Best-case throughput: 1 instr / 2 cycles with 1-cycle memory. Latency from
//   imem_req to valid_out is (memory latency + 1) cycles.
// - Redirect has the highest priority and overrides stall in the same cycle:
//   - pc<=redirect_pc; IF/ID flushed to bubble; hold buffer discarded; halted<=0.
//   - WAIT without imem_done -> DRAIN. WAIT with imem_done -> REQ, data discarded.
//   - REQ, HOLD, HALTED -> REQ. DRAIN stays DRAIN.
// - DRAIN: discard the next imem_done, then -> REQ. Never more than one outstanding.
// - imem_err with imem_done: err<=1 (sticky until reset); the data is replaced by a
//   bubble and pc still advances.
// - Arithmetic: pc+2 is modulo 2^16, so 16'hFFFE wraps to 16'h0000.
// - imem_done in REQ, HOLD or HALTED (no request outstanding): err<=1, response ignored.
// CONFIGURATION
// - FETCH_ALIGN_CHK_EN defined: a redirect with redirect_pc[0]==1 sets err<=1. The
//   redirect is still taken, with bit 0 cleared.
// - Undefined: bit 0 of redirect_pc is silently cleared and err is not affected.
// TESTING
// - Reset, 1-cycle memory, no stall. Fetch 0x0000 then 0x0002 -> imem_addr=0x0000;
//   IF/ID={data,0x0002,1} 2 cycles later; next request addr 0x0002.
// - stall=1 for 3 cycles while imem_done arrives -> IF/ID held, HOLD entered. When
//   stall drops, the buffered instr appears, then imem_addr=pc+2.
// - redirect to 0x0040 in WAIT, done 2 cycles later -> IF/ID bubble, stale data dropped,
//   next imem_addr=0x0040.
// - Fetch 16'h0000 (HALT) -> valid_out=1 with HALT, halted=1, no further imem_req.
//   Then redirect to 0x0010 -> halted=0, fetch resumes at 0x0010.
// - pc=0xFFFE -> next_pc_out=0x0000. imem_err with done -> err=1 sticky, bubble.
// - With FETCH_ALIGN_CHK_EN: redirect_pc=0x0011 -> err=1, imem_addr=0x0010.
//   Without it: err=0, imem_addr=0x0010.

Source files
------------

// File: rtl/fetch_mem_stage.sv
// fetch_mem_stage: IF stage owning the PC, one-outstanding req/done instruction fetch, IF/ID register.
// Optional macro FETCH_ALIGN_CHK_EN: odd redirect targets raise the sticky error.
module fetch_mem_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OP   = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_done,
    input  logic [15:0] imem_data,
    input  logic        imem_err,
    output logic [15:0] instr_out,
    output logic [15:0] next_pc_out,
    output logic        valid_out,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_REQ    = 3'd0,
        ST_WAIT   = 3'd1,
        ST_HOLD   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] pc_r, pc_s;
    logic [15:0] instr_r, instr_s;
    logic [15:0] next_pc_r, next_pc_s;
    logic [15:0] hold_instr_r, hold_instr_s;
    logic        valid_r, valid_s;
    logic        halted_r, halted_s;
    logic        err_r, err_s;
    logic        hold_ok_r, hold_ok_s;
    logic        armed_r;
    logic        req_s, spurious_s, resp_err_s, align_err_s;
    logic        deliver_s, deliver_ok_s;
    logic [15:0] deliver_word_s, resp_word_s, redirect_tgt_s, pc_inc_s;

    function automatic logic is_halt(input logic [15:0] word);
        return (word[15:11] == HALT_OP);
    endfunction

    // Request decode and error sources; a redirect suppresses the request issued in REQ
    always_comb begin
        req_s          = (state_r == ST_REQ) && armed_r && !redirect;
        spurious_s     = imem_done && ((state_r == ST_REQ) || (state_r == ST_HOLD) ||
                                       (state_r == ST_HALTED));
        resp_err_s     = imem_done && imem_err && (state_r == ST_WAIT) && !redirect;
        resp_word_s    = imem_err ? NOP_INSTR : imem_data;
        redirect_tgt_s = redirect_pc & 16'hFFFE;
        pc_inc_s       = pc_r + 16'd2;
`ifdef FETCH_ALIGN_CHK_EN
        align_err_s    = redirect && redirect_pc[0];
`else
        align_err_s    = 1'b0;
`endif
    end

    // Next-state, PC, IF/ID and hold-buffer update
    always_comb begin
        state_s        = state_r;
        pc_s           = pc_r;
        instr_s        = instr_r;
        next_pc_s      = next_pc_r;
        valid_s        = valid_r;
        halted_s       = halted_r;
        hold_instr_s   = hold_instr_r;
        hold_ok_s      = hold_ok_r;
        deliver_s      = 1'b0;
        deliver_ok_s   = 1'b0;
        deliver_word_s = NOP_INSTR;
        err_s          = err_r | spurious_s | resp_err_s | align_err_s;
        if (redirect) begin
            pc_s         = redirect_tgt_s;
            instr_s      = NOP_INSTR;
            valid_s      = 1'b0;
            hold_instr_s = NOP_INSTR;
            hold_ok_s    = 1'b0;
            halted_s     = 1'b0;
            // A response arriving alongside the redirect completes the drain on its own
            case (state_r)
                ST_WAIT, ST_DRAIN: state_s = imem_done ? ST_REQ : ST_DRAIN;
                default:           state_s = ST_REQ;
            endcase
        end else begin
            if (!stall) begin
                instr_s = NOP_INSTR;
                valid_s = 1'b0;
            end else begin
                instr_s = instr_r;
                valid_s = valid_r;
            end
            case (state_r)
                ST_REQ:  state_s = armed_r ? ST_WAIT : ST_REQ;
                ST_WAIT: begin
                    if (imem_done && stall) begin
                        hold_instr_s = resp_word_s;
                        hold_ok_s    = !imem_err;
                        state_s      = ST_HOLD;
                    end else if (imem_done) begin
                        deliver_s      = 1'b1;
                        deliver_word_s = resp_word_s;
                        deliver_ok_s   = !imem_err;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        deliver_s      = 1'b1;
                        deliver_word_s = hold_instr_r;
                        deliver_ok_s   = hold_ok_r;
                        hold_instr_s   = NOP_INSTR;
                        hold_ok_s      = 1'b0;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                ST_DRAIN:  state_s = imem_done ? ST_REQ : ST_DRAIN;
                ST_HALTED: state_s = ST_HALTED;
                default:   state_s = ST_REQ;
            endcase
            // Errored responses still consume their slot: PC advances, IF/ID gets a bubble
            if (deliver_s) begin
                pc_s = pc_inc_s;
                if (deliver_ok_s) begin
                    instr_s   = deliver_word_s;
                    next_pc_s = pc_inc_s;
                    valid_s   = 1'b1;
                end else begin
                    instr_s = NOP_INSTR;
                    valid_s = 1'b0;
                end
                if (deliver_ok_s && is_halt(deliver_word_s)) begin
                    state_s  = ST_HALTED;
                    halted_s = 1'b1;
                end else begin
                    state_s = ST_REQ;
                end
            end else begin
                pc_s = pc_r;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_REQ;
            pc_r         <= RESET_PC;
            instr_r      <= NOP_INSTR;
            next_pc_r    <= 16'h0000;
            valid_r      <= 1'b0;
            halted_r     <= 1'b0;
            err_r        <= 1'b0;
            hold_instr_r <= NOP_INSTR;
            hold_ok_r    <= 1'b0;
            armed_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            instr_r      <= instr_s;
            next_pc_r    <= next_pc_s;
            valid_r      <= valid_s;
            halted_r     <= halted_s;
            err_r        <= err_s;
            hold_instr_r <= hold_instr_s;
            hold_ok_r    <= hold_ok_s;
            armed_r      <= 1'b1;
        end
    end

    assign imem_req    = req_s;
    assign imem_addr   = pc_r;
    assign instr_out   = instr_r;
    assign next_pc_out = next_pc_r;
    assign valid_out   = valid_r;
    assign halted      = halted_r;
    assign err         = err_r;

endmodule

// File: tb/tb_fetch_mem_stage.sv
// tb_fetch_mem_stage: directed + random fetch traffic against a transaction-level model of the IF stage.
module tb_fetch_mem_stage;

    localparam logic [15:0] NOP = 16'h0800;
`ifdef FETCH_ALIGN_CHK_EN
    localparam logic [15:0] ALIGN_ERR = 16'd1;
`else
    localparam logic [15:0] ALIGN_ERR = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, redirect, imem_done, imem_err;
    logic [15:0] redirect_pc, imem_data;
    logic        imem_req, valid_out, halted, err;
    logic [15:0] imem_addr, instr_out, next_pc_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // memory responder
    logic        mem_pend, spur, resp_err;
    int          mem_due, lat;
    logic [15:0] resp_data;
    logic        seen_req;
    logic [15:0] seen_addr;

    // reference model: transaction view of the stage
    logic        m_out, m_disc, m_holdv, m_holdok, m_halted, m_err, m_valid, m_armed;
    logic [15:0] m_pc, m_npc, m_instr, m_holdw;

    fetch_mem_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_done(imem_done),
        .imem_data(imem_data), .imem_err(imem_err), .instr_out(instr_out),
        .next_pc_out(next_pc_out), .valid_out(valid_out), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_regs();
        chk("instr_out", instr_out, m_instr);
        chk("next_pc_out", next_pc_out, m_npc);
        chk("valid_out", valid_out, m_valid);
        chk("halted", halted, m_halted);
        chk("err", err, m_err);
    endtask

    task automatic do_reset();
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        imem_done = 1'b0; imem_err = 1'b0; imem_data = 16'h0;
        mem_pend = 1'b0; spur = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        m_out = 0; m_disc = 0; m_holdv = 0; m_holdok = 0; m_holdw = NOP;
        m_halted = 0; m_err = 0; m_valid = 0; m_armed = 0;
        m_pc = 16'h0000; m_npc = 16'h0000; m_instr = NOP;
        chk("reset_req", imem_req, 16'd0);
        check_regs();
        rst = 1'b1;
    endtask

    // Apply the spec's rules to one clock edge
    task automatic model_step(input logic st, input logic rd, input logic [15:0] rp,
                              input logic dn, input logic [15:0] dat, input logic ie,
                              input logic ereq);
        logic        dlv, ok;
        logic [15:0] word;
        dlv = 0; ok = 0; word = NOP;
        if (dn && !m_out) m_err = 1;
        if (rd) begin
            m_pc = {rp[15:1], 1'b0};
            m_instr = NOP; m_valid = 0; m_holdv = 0; m_halted = 0;
            if (rp[0] && ALIGN_ERR[0]) m_err = 1;
            if (m_out && dn) begin m_out = 0; m_disc = 0; end
            else if (m_out) m_disc = 1;
        end else begin
            if (m_out && dn) begin
                m_out = 0;
                if (m_disc) m_disc = 0;
                else begin
                    ok = !ie; word = ie ? NOP : dat;
                    if (ie) m_err = 1;
                    if (st) begin m_holdv = 1; m_holdw = word; m_holdok = ok; end
                    else dlv = 1;
                end
            end else if (m_holdv && !st) begin
                dlv = 1; word = m_holdw; ok = m_holdok; m_holdv = 0;
            end
            if (ereq) m_out = 1;
            if (dlv) begin
                if (ok) begin
                    m_instr = word; m_npc = m_pc + 16'd2; m_valid = 1;
                    if (word[15:11] == 5'b00000) m_halted = 1;
                end else begin
                    m_instr = NOP; m_valid = 0;
                end
                m_pc = m_pc + 16'd2;
            end else if (!st) begin
                m_instr = NOP; m_valid = 0;
            end
        end
        m_armed = 1;
    endtask

    task automatic cycle(input logic st, input logic rd, input logic [15:0] rp);
        logic ereq;
        stall = st; redirect = rd; redirect_pc = rp;
        if (mem_pend && cyc == mem_due) begin
            imem_done = 1'b1; mem_pend = 1'b0;
        end else begin
            imem_done = spur;
        end
        imem_data = resp_data;
        imem_err = imem_done & resp_err;
        #1;
        ereq = m_armed && !m_out && !m_holdv && !m_halted && !rd;
        seen_req = imem_req; seen_addr = imem_addr;
        chk("imem_req", imem_req, ereq);
        if (ereq) chk("imem_addr", imem_addr, m_pc);
        if (imem_req === 1'b1) begin mem_pend = 1'b1; mem_due = cyc + lat; end
        @(posedge clk);
        model_step(st, rd, rp, imem_done, imem_data, imem_err, ereq);
        #1;
        check_regs();
        cyc++;
    endtask

    initial begin
        lat = 1; resp_data = 16'h1234; resp_err = 1'b0; spur = 1'b0;
        do_reset();
        // basic fetch with 1-cycle memory
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("first_req", seen_req, 16'd1);
        chk("first_addr", seen_addr, 16'h0000);
        cycle(0, 0, 0);
        chk("f0_instr", instr_out, 16'h1234);
        chk("f0_npc", next_pc_out, 16'h0002);
        chk("f0_valid", valid_out, 16'd1);
        resp_data = 16'hA5A5;
        cycle(0, 0, 0);
        chk("second_addr", seen_addr, 16'h0002);
        // stall across the response
        cycle(1, 0, 0);
        chk("stall_valid", valid_out, 16'd0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        chk("hold_instr", instr_out, 16'hA5A5);
        chk("hold_npc", next_pc_out, 16'h0004);
        chk("hold_valid", valid_out, 16'd1);
        // redirect while waiting; stale response is dropped
        lat = 3; resp_data = 16'h7777;
        cycle(0, 0, 0);
        chk("pre_redir_addr", seen_addr, 16'h0004);
        cycle(0, 1, 16'h0040);
        chk("redir_instr", instr_out, NOP);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("stale_valid", valid_out, 16'd0);
        lat = 1; resp_data = 16'h0000;
        cycle(0, 0, 0);
        chk("redir_addr", seen_addr, 16'h0040);
        // HALT then resume by redirect
        cycle(0, 0, 0);
        chk("halt_instr", instr_out, 16'h0000);
        chk("halt_valid", valid_out, 16'd1);
        chk("halt_flag", halted, 16'd1);
        cycle(0, 0, 0);
        chk("halt_noreq0", seen_req, 16'd0);
        cycle(0, 0, 0);
        chk("halt_noreq1", seen_req, 16'd0);
        cycle(0, 1, 16'h0010);
        chk("unhalt", halted, 16'd0);
        resp_data = 16'h1111;
        cycle(0, 0, 0);
        chk("resume_addr", seen_addr, 16'h0010);
        cycle(0, 0, 0);
        // PC wrap at 0xFFFE
        cycle(0, 1, 16'hFFFE);
        chk("redir_req_supp", seen_req, 16'd0);
        resp_data = 16'h2222;
        cycle(0, 0, 0);
        chk("wrap_addr", seen_addr, 16'hFFFE);
        cycle(0, 0, 0);
        chk("wrap_npc", next_pc_out, 16'h0000);
        chk("wrap_instr", instr_out, 16'h2222);
        resp_err = 1'b1;
        cycle(0, 0, 0);
        chk("post_wrap_addr", seen_addr, 16'h0000);
        // errored response: sticky err, bubble, PC still advances
        cycle(0, 0, 0);
        chk("ierr_err", err, 16'd1);
        chk("ierr_valid", valid_out, 16'd0);
        resp_err = 1'b0; resp_data = 16'h3333;
        cycle(0, 0, 0);
        chk("ierr_adv_addr", seen_addr, 16'h0002);
        cycle(0, 0, 0);
        chk("err_sticky", err, 16'd1);
        chk("after_err_valid", valid_out, 16'd1);
        // misaligned redirect, then a response with nothing outstanding
        do_reset();
        cycle(0, 1, 16'h0011);
        chk("align_err", err, ALIGN_ERR);
        resp_data = 16'h4444;
        cycle(0, 0, 0);
        chk("align_addr", seen_addr, 16'h0010);
        cycle(0, 0, 0);
        spur = 1'b1;
        cycle(0, 0, 0);
        spur = 1'b0;
        chk("spurious_err", err, 16'd1);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic st, rd;
            lat = 1 + int'($urandom % 3);
            resp_data = 16'($urandom);
            resp_err = (($urandom % 16) == 0);
            st = (($urandom % 4) == 0);
            rd = (($urandom % 12) == 0);
            cycle(st, rd, 16'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
